byte_word_packer: RTL and testbench

Upstream feeder for the 32-bit FSM stages: collects a byte stream into 32-bit words and presents them on a word port that drives a downstream stage's 32-bit `in1` input. Valid/ready handshakes on both sides. A one-word output buffer lets the next word assemble while the current one waits, so the packer sustains one byte per cycle. Optionally flushes a stalled partial word after an idle timeout.

---
 rtl/byte_word_packer.sv | 159 +++++++++++++++
 tb/tb_byte_word_packer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_word_packer.sv
// byte_word_packer
//   Collects a byte stream into little-endian 32-bit words for a downstream
//   32-bit stage. A one-word output buffer lets the next word assemble while
//   the current one waits, so one byte per cycle is sustained.
//
//   Optional feature macro: PACKER_FLUSH_EN
//     When defined, a partial word that sits idle for FLUSH_CYCLES cycles is
//     flushed zero-padded, with out_count giving the number of valid bytes.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_data    in   [7:0]  input byte
//   in_valid   in   in_data valid
//   in_ready   out  byte accepted this cycle when in_valid is high
//   out1       out  [31:0] assembled word (registered)
//   out_valid  out  out1 holds a word
//   out_ready  in   downstream consumes out1 this cycle
//   out_count  out  [2:0]  valid bytes in out1 (1..4)
//
// state | meaning
// IDLE  | assembly register empty (byteCnt == 0)
// FILL  | assembly register holds 1..3 bytes

module byte_word_packer #(
    parameter int FLUSH_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_count
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 255) begin : g_paramCheck
        $error("byte_word_packer: FLUSH_CYCLES must be in 1..255");
    end

    typedef enum logic {IDLE, FILL} state_t;

    state_t      state, stateNext;
    logic [1:0]  byteCnt, byteCntNext;
    logic [23:0] asmReg;
    logic        byteAcc;
    logic        wordAcc;
    logic        bufFree;
    logic        loadFull;
    logic        loadFlush;
    logic        load;
    logic [31:0] loadWord;
    logic [2:0]  loadCount;

    // Only the fourth byte needs the output buffer, so only it can stall.
    assign in_ready = !(byteCnt == 2'd3 && out_valid && !out_ready);
    assign byteAcc  = in_valid && in_ready;
    assign wordAcc  = out_valid && out_ready;
    assign bufFree  = !out_valid || out_ready;

`ifdef PACKER_FLUSH_EN
    localparam logic [7:0] FLUSH_TC = 8'(FLUSH_CYCLES);

    logic [7:0] idleTimer;

    // A byte accept outranks a flush in the same cycle.
    assign loadFlush = (state == FILL) && (idleTimer == FLUSH_TC) && !byteAcc && bufFree;

    // Saturates at the terminal count so a blocked flush fires as soon as
    // the buffer frees up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idleTimer <= 8'd0;
        end else if (byteAcc || loadFlush || state != FILL) begin
            idleTimer <= 8'd0;
        end else if (idleTimer != FLUSH_TC) begin
            idleTimer <= idleTimer + 8'd1;
        end
    end
`else
    assign loadFlush = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            byteCnt <= 2'd0;
        end else begin
            state   <= stateNext;
            byteCnt <= byteCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        byteCntNext = byteCnt;
        loadFull    = 1'b0;
        case (state)
            IDLE: begin
                if (byteAcc) begin
                    stateNext   = FILL;
                    byteCntNext = 2'd1;
                end
            end
            FILL: begin
                if (byteAcc) begin
                    if (byteCnt == 2'd3) begin
                        loadFull    = 1'b1;
                        byteCntNext = 2'd0;
                        stateNext   = IDLE;
                    end else begin
                        byteCntNext = byteCnt + 2'd1;
                    end
                end else if (loadFlush) begin
                    byteCntNext = 2'd0;
                    stateNext   = IDLE;
                end
            end
            default: begin
                stateNext   = IDLE;
                byteCntNext = 2'd0;
            end
        endcase
    end

    assign load = loadFull || loadFlush;

    // asmReg is cleared whenever a word leaves it, so unwritten upper bytes
    // are already zero and a flushed partial word needs no masking.
    assign loadWord  = loadFull ? {in_data, asmReg} : {8'h00, asmReg};
    assign loadCount = loadFull ? 3'd4 : {1'b0, byteCnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asmReg <= 24'd0;
        end else if (load) begin
            asmReg <= 24'd0;
        end else if (byteAcc) begin
            asmReg[8*byteCnt +: 8] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1      <= 32'd0;
            out_valid <= 1'b0;
            out_count <= 3'd0;
        end else if (load) begin
            out1      <= loadWord;
            out_valid <= 1'b1;
            out_count <= loadCount;
        end else if (wordAcc) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out1;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    byte_word_packer #(.FLUSH_CYCLES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out1      (out1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] expWord;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_out1",      out1,            32'h0);
        chk("rst_out_valid", 32'(out_valid),  32'h0);
        chk("rst_out_count", 32'(out_count),  32'h0);
        chk("rst_in_ready",  32'(in_ready),   32'h1);
        #20;
        rst_n = 1'b1;
        tick();

        // Basic word
        out_ready = 1'b1;
        sendByte(8'h11);
        sendByte(8'h22);
        sendByte(8'h33);
        chk("basic_no_early_valid", 32'(out_valid), 32'h0);
        sendByte(8'h44);
        chk("basic_valid", 32'(out_valid), 32'h1);
        chk("basic_word",  out1,           32'h44332211);
        chk("basic_count", 32'(out_count), 32'h4);
        tick();
        chk("basic_one_cycle", 32'(out_valid), 32'h0);

        // Streaming 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            chk($sformatf("stream_in_ready%0d", i), 32'(in_ready), 32'h1);
            tick();
            if (i % 4 == 3) begin
                expWord = {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)};
                chk($sformatf("stream_valid%0d", i / 4), 32'(out_valid), 32'h1);
                chk($sformatf("stream_word%0d", i / 4),  out1,           expWord);
            end else begin
                chk($sformatf("stream_idle%0d", i), 32'(out_valid), 32'h0);
            end
        end
        in_valid = 1'b0;
        tick();

        // Backpressure
        out_ready = 1'b0;
        sendByte(8'h11);
        sendByte(8'h12);
        sendByte(8'h13);
        sendByte(8'h14);
        chk("bp_first_word", out1, 32'h14131211);
        sendByte(8'h15);
        sendByte(8'h16);
        chk("bp_ready_before_17", 32'(in_ready), 32'h1);
        sendByte(8'h17);
        chk("bp_ready_low", 32'(in_ready), 32'h0);
        in_valid = 1'b1;
        in_data  = 8'h18;
        tick();
        chk("bp_held_word",  out1,           32'h14131211);
        chk("bp_held_count", 32'(out_count), 32'h4);
        chk("bp_still_low",  32'(in_ready),  32'h0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp_second_word",  out1,           32'h18171615);
        chk("bp_second_valid", 32'(out_valid), 32'h1);
        chk("bp_second_count", 32'(out_count), 32'h4);
        tick();
        chk("bp_second_held", out1, 32'h18171615);

        // Reset mid-word with a word waiting in the buffer
        sendByte(8'hAA);
        sendByte(8'hBB);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out1",      out1,           32'h0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_out_count", 32'(out_count), 32'h0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'h1);
        #1;
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        sendByte(8'h01);
        sendByte(8'h02);
        chk("post_rst_no_stale_word", 32'(out_valid), 32'h0);
        sendByte(8'h03);
        chk("post_rst_no_early", 32'(out_valid), 32'h0);
        sendByte(8'h04);
        chk("post_rst_valid", 32'(out_valid), 32'h1);
        chk("post_rst_word",  out1,           32'h04030201);
        tick();
        chk("post_rst_single", 32'(out_valid), 32'h0);

`ifdef PACKER_FLUSH_EN
        // Idle flush of a partial word
        sendByte(8'hAA);
        sendByte(8'hBB);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 16) begin
                chk("flush_not_early", 32'(out_valid), 32'h0);
            end
        end
        chk("flush_valid", 32'(out_valid), 32'h1);
        chk("flush_word",  out1,           32'h0000BBAA);
        chk("flush_count", 32'(out_count), 32'h2);
        tick();
        chk("flush_drained", 32'(out_valid), 32'h0);

        // Flush blocked by a full buffer
        out_ready = 1'b0;
        sendByte(8'h21);
        sendByte(8'h22);
        sendByte(8'h23);
        sendByte(8'h24);
        sendByte(8'h55);
        repeat (40) tick();
        chk("blocked_word",  out1,           32'h24232221);
        chk("blocked_count", 32'(out_count), 32'h4);
        chk("blocked_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        tick();
        chk("blocked_flush_word",  out1,           32'h00000055);
        chk("blocked_flush_count", 32'(out_count), 32'h1);
        chk("blocked_flush_valid", 32'(out_valid), 32'h1);
        tick();
        chk("blocked_flush_drained", 32'(out_valid), 32'h0);
`else
        // Without the flush feature a partial word waits indefinitely
        sendByte(8'hAA);
        sendByte(8'hBB);
        repeat (100) tick();
        chk("noflush_idle", 32'(out_valid), 32'h0);
        sendByte(8'hCC);
        sendByte(8'hDD);
        chk("noflush_word",  out1,           32'hDDCCBBAA);
        chk("noflush_valid", 32'(out_valid), 32'h1);
        chk("noflush_count", 32'(out_count), 32'h4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
